zone_scan_scheduler: RTL

- Round-robin scheduler that shares one service resource (lighting/actuator channel) between 4 smart-home zones.
- Built on the 0..3 zone-counter-with-terminal-count pattern: a 2-bit zone pointer plus a TC pulse when the scan wraps.
- Adds request arbitration, a per-grant dwell timer and alarm preemption.
- Sits between the zone sensor/request logic and the shared actuator mux, which is driven by GNT/ZONE.

---
 rtl/zone_scan_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/zone_scan_scheduler.sv
// Round-robin scheduler that shares one actuator channel between 4 zones,
// with a per-grant dwell timer and alarm preemption.
//
//   state | meaning
//   IDLE  | no grant, waiting for a request or an alarm
//   ARB   | dead cycle between grants; picks the next alarm or requester
//   GRANT | normal grant of ZONE, limited by the dwell timer
//   ALRM  | alarm grant of ZONE, held until ALARM[ZONE] drops
module zone_scan_scheduler #(
    parameter int DWELL = 4,
    parameter int DW    = 4
) (
    input  logic       CLK_IN,
    input  logic       CLR_FF,
    input  logic       EN,
    input  logic       TICK,
    input  logic [3:0] REQ,
    input  logic [3:0] ALARM,
    output logic [3:0] GNT,
    output logic [1:0] ZONE,
    output logic       BUSY,
    output logic       ALARM_ACT,
    output logic       TC
);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, ALRM} state_t;

    state_t        state, state_nxt;
    logic [1:0]    zone_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic          tc_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    alarm_zone;
    logic [1:0]    rr_zone;
    logic [1:0]    rr_idx;
    logic          rr_found;

    // Lowest-index alarm wins.
    always_comb begin
        alarm_zone = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ALARM[i]) alarm_zone = 2'(i);
        end
    end

    // Search starts one past the last granted zone and wraps.
    always_comb begin
        rr_zone  = ZONE;
        rr_found = 1'b0;
        rr_idx   = ZONE;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = ZONE + 2'(i);
            if (!rr_found && REQ[rr_idx]) begin
                rr_zone  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        zone_nxt  = ZONE;
        dwell_nxt = dwell;
        tc_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (|ALARM || (EN && |REQ)) state_nxt = ARB;
            end
            ARB: begin
                if (|ALARM) begin
                    zone_nxt  = alarm_zone;
                    state_nxt = ALRM;
                end else if (EN && |REQ) begin
                    zone_nxt  = rr_zone;
                    dwell_nxt = DW'(DWELL);
                    tc_nxt    = (rr_zone <= ZONE);
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (TICK && dwell != '0) dwell_nxt = dwell - DW'(1);
                if ((TICK && dwell <= DW'(1)) || !REQ[ZONE] || |ALARM || !EN)
                    state_nxt = ARB;
            end
            ALRM: begin
                if (!ALARM[ZONE]) state_nxt = ARB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state.
    assign gnt_nxt = (state_nxt == GRANT || state_nxt == ALRM) ? (4'b0001 << zone_nxt) : 4'b0000;

    always_ff @(posedge CLK_IN or negedge CLR_FF) begin
        if (!CLR_FF) begin
            state     <= IDLE;
            ZONE      <= 2'd3;
            dwell     <= '0;
            GNT       <= 4'b0000;
            BUSY      <= 1'b0;
            ALARM_ACT <= 1'b0;
            TC        <= 1'b0;
        end else begin
            state     <= state_nxt;
            ZONE      <= zone_nxt;
            dwell     <= dwell_nxt;
            GNT       <= gnt_nxt;
            BUSY      <= (state_nxt == GRANT) || (state_nxt == ALRM);
            ALARM_ACT <= (state_nxt == ALRM);
            TC        <= tc_nxt;
        end
    end

endmodule
